// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the MEM/WB stage: default widths,
// the write-back entry layout and the hard-wired zero register index.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;
  localparam int CPU_ADDR_W = 5;

  // Register index whose writes are architecturally discarded.
  localparam int unsigned ZERO_REG = 0;

  // Entry layout at the default widths. Parametrised modules mirror this
  // field order in a local typedef so the packed bit layout is identical.
  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic [CPU_DATA_W-1:0] res;
    logic [CPU_DATA_W-1:0] dato;
    logic [CPU_ADDR_W-1:0] aw;
    logic [CPU_DATA_W-1:0] wbdata;
  } wb_entry_t;

  // Packed width of an entry for arbitrary data/address widths.
  function automatic int entry_w(input int dw, input int aw);
    return 2 + 3 * dw + aw;
  endfunction

endpackage

// File: rtl/mem_wb_skid_stage_if.sv
// MEM/WB handshake bundle: upstream entry, downstream head and flush.
// master = pipeline control side (memory stage + write-back consumer),
// slave  = the MEM/WB register itself.
interface mem_wb_skid_stage_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_regwrite;
  logic              in_memtoreg;
  logic [DATA_W-1:0] in_res;
  logic [DATA_W-1:0] in_dato;
  logic [ADDR_W-1:0] in_aw;
  logic              out_valid;
  logic              out_ready;
  logic              out_regwrite;
  logic              out_memtoreg;
  logic [DATA_W-1:0] out_res;
  logic [DATA_W-1:0] out_dato;
  logic [ADDR_W-1:0] out_aw;
  logic [DATA_W-1:0] out_wbdata;

  modport master (
    output flush, in_valid, in_regwrite, in_memtoreg, in_res, in_dato, in_aw,
    output out_ready,
    input  in_ready,
    input  out_valid, out_regwrite, out_memtoreg, out_res, out_dato, out_aw,
    input  out_wbdata
  );

  modport slave (
    input  flush, in_valid, in_regwrite, in_memtoreg, in_res, in_dato, in_aw,
    input  out_ready,
    output in_ready,
    output out_valid, out_regwrite, out_memtoreg, out_res, out_dato, out_aw,
    output out_wbdata
  );
endinterface

// File: rtl/mem_wb_skid_stage_pack.sv
// Combinational entry builder: applies the $zero write guard and
// precomputes the write-back mux so the stage output is a plain flop.
module wb_entry_pack
  import cpu_pkg::*;
#(
  parameter int DATA_W     = CPU_DATA_W,
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter bit ZERO_GUARD = 1'b1,
  parameter int ENTRY_W    = entry_w(DATA_W, ADDR_W)
) (
  input  logic               regwrite,
  input  logic               memtoreg,
  input  logic [DATA_W-1:0]  res,
  input  logic [DATA_W-1:0]  dato,
  input  logic [ADDR_W-1:0]  aw,
  output logic [ENTRY_W-1:0] entry
);
  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] dato;
    logic [ADDR_W-1:0] aw;
    logic [DATA_W-1:0] wbdata;
  } entry_t;

  entry_t e;
  logic   to_zero;

  assign to_zero = ZERO_GUARD && (aw == ADDR_W'(ZERO_REG));

  // Build the entry; the mux is written bitwise so each bit is an AND-OR.
  always_comb begin
    e          = '0;
    e.regwrite = regwrite && !to_zero;
    e.memtoreg = memtoreg;
    e.res      = res;
    e.dato     = dato;
    e.aw       = aw;
    e.wbdata   = ({DATA_W{memtoreg}} & dato) | ({DATA_W{~memtoreg}} & res);
  end

  assign entry = e;
endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register with a 2-entry skid buffer. in_ready comes
// straight from a flop so the write-back stall never reaches upstream
// combinationally; flush empties the stage and drops same-cycle input.
module mem_wb_skid_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W     = CPU_DATA_W,
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter bit ZERO_GUARD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_wb_skid_stage_if.slave    bus
);
  localparam int ENTRY_W = entry_w(DATA_W, ADDR_W);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] dato;
    logic [ADDR_W-1:0] aw;
    logic [DATA_W-1:0] wbdata;
  } entry_t;

  logic [ENTRY_W-1:0] in_bits;
  entry_t             in_ent;
  entry_t             main_q;
  entry_t             skid_q;
  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic               in_ready_q;
  logic               main_valid;
  logic               acc;
  logic               pop;
  logic               main_ld;
  logic               main_from_skid;
  logic               skid_ld;

  wb_entry_pack #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .ZERO_GUARD (ZERO_GUARD),
    .ENTRY_W    (ENTRY_W)
  ) u_pack (
    .regwrite (bus.in_regwrite),
    .memtoreg (bus.in_memtoreg),
    .res      (bus.in_res),
    .dato     (bus.in_dato),
    .aw       (bus.in_aw),
    .entry    (in_bits)
  );

  assign in_ent     = in_bits;
  assign main_valid = (state_q != EMPTY);
  assign acc        = bus.in_valid && in_ready_q;
  assign pop        = main_valid && bus.out_ready;

  // Occupancy transitions and which register loads from where.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (acc) begin
          main_ld = 1'b1;
          state_d = ONE;
        end
        ONE: begin
          if (acc && pop) begin
            main_ld = 1'b1;
          end else if (acc) begin
            skid_ld = 1'b1;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: if (pop) begin
          main_from_skid = 1'b1;
          state_d        = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and the registered ready, which is low only while FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Head entry: fresh input or promoted skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              main_q <= '0;
    else if (main_ld)        main_q <= in_ent;
    else if (main_from_skid) main_q <= skid_q;
  end

  // Overflow entry captured while the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       skid_q <= '0;
    else if (skid_ld) skid_q <= in_ent;
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = main_valid;
  assign bus.out_regwrite = main_valid && main_q.regwrite;
  assign bus.out_memtoreg = main_q.memtoreg;
  assign bus.out_res      = main_q.res;
  assign bus.out_dato     = main_q.dato;
  assign bus.out_aw       = main_q.aw;
  assign bus.out_wbdata   = main_q.wbdata;
endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
Parametrised MEM/WB pipeline register for the processor datapath, replacing the fixed 32-bit always-load stage. It carries the write-back control and data (regwrite, memtoreg, ALU result, memory data, destination register) with a valid/ready handshake. A 2-entry skid buffer lets the write-back side stall without combinational ready paths. It also supports flush, $zero write suppression and a registered write-back mux output. It sits between the memory-access stage and the register file / forwarding unit.

Parameters:
DATA_W, 32, width of ALU result, memory data and write-back data
ADDR_W, 5, width of destination register address
ZERO_GUARD, 1, when 1 a regwrite to address 0 is forced to 0 at capture

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  discard all held entries and the current input
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry this cycle
in_regwrite  input  1  register-file write enable
in_memtoreg  input  1  select memory data (1) or ALU result (0) for write-back
in_res  input  DATA_W  ALU result
in_dato  input  DATA_W  memory read data
in_aw  input  ADDR_W  destination register
out_valid  output  1  head entry valid
out_ready  input  1  downstream consumes head entry
out_regwrite  output  1  head regwrite, gated by out_valid
out_memtoreg  output  1  head memtoreg
out_res  output  DATA_W  head ALU result
out_dato  output  DATA_W  head memory data
out_aw  output  ADDR_W  head destination
out_wbdata  output  DATA_W  registered write-back value: out_memtoreg ? out_dato : out_res

Behaviour:
- Reset is asynchronous on rst_n low. The main and skid valid bits clear, and every data/control output is 0; in_ready is 1 during reset and after release.
- Storage: a main entry drives out_*, and a skid entry holds overflow. An entry is {regwrite, memtoreg, res, dato, aw, wbdata}. wbdata is computed at capture, so out_wbdata has no combinational mux after the flop.
- Occupancy FSM: EMPTY (no entries), ONE (main valid), FULL (main+skid valid). in_ready = !skid_valid, driven straight from a flop.
- Accept condition: in_valid && in_ready. Pop condition: out_valid && out_ready.
- EMPTY: an accept loads main and moves to ONE. Latency is 1 cycle from accept to out_valid.
- ONE: pop only -> EMPTY. Accept only -> skid loads, move to FULL. Accept and pop together -> main reloads from the input, stay ONE.
- FULL: pop moves skid to main -> ONE. No accept is possible since in_ready=0.
- Flush (synchronous) has priority over everything. Next cycle is EMPTY, and any same-cycle accept is dropped. Data registers may keep stale values, but out_regwrite must read 0 whenever out_valid=0.
- out_regwrite = main_valid && main.regwrite. This makes a bubble never write the register file.
- ZERO_GUARD=1: an entry with aw==0 is stored with regwrite=0; other fields are unchanged.
- Ordering is strict FIFO: entries leave in acceptance order, none is duplicated, and none is lost except by flush.
- Width: all data fields are pass-through at DATA_W with no arithmetic. wbdata selection is bitwise.
- Reset asserted mid-operation clears all state immediately; in-flight entries are lost by design.

Decomposition:
- Shared package (cpu_pkg): DATA_W/ADDR_W defaults, a wb_entry_t struct {regwrite, memtoreg, res, dato, aw, wbdata}, and a ZERO_REG constant.
- One natural sub-module: wb_entry_pack. It is combinational; it builds wb_entry_t from the inputs, applying ZERO_GUARD and computing the wbdata mux.
- The skid/FSM logic stays in the top module.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_*=0, in_ready=1. Release, then apply res=0x0000_0010, memtoreg=0, aw=3, regwrite=1 -> next cycle out_valid=1, out_wbdata=0x10, out_aw=3.
- Mux: accept memtoreg=1, res=0x1111_1111, dato=0xDEAD_BEEF -> out_wbdata=0xDEAD_BEEF.
- Backpressure: out_ready=0, stream A,B,C back to back -> A in main, B in skid, in_ready=0 at cycle 3 and C held upstream. Release out_ready -> order A,B,C with no loss.
- Flush: FULL state, assert flush with in_valid=1 (D) -> next cycle out_valid=0, out_regwrite=0, in_ready=1; D never appears.
- Zero guard: accept aw=0, regwrite=1 -> out_regwrite=0, out_valid=1. With ZERO_GUARD=0 -> out_regwrite=1.
- Stream: accept every cycle with out_ready=1 for 100 random entries -> throughput 1/cycle, scoreboard matches order and all fields.
